sort_stream_loader: RTL
=======================

Name: sort_stream_loader

Overview:
- Sequencer between the CPU-visible peripheral and the sort accelerator core.
- Reads 2**LOG_INPUT_NUM words from a synchronous source RAM and streams them into the sorter. Starts the sort, collects every output word and writes each one to a destination RAM.
- Firmware writes two base addresses, pulses start, then polls busy/done. This replaces per-word register writes to the sorter.

Parameters:
- LOG_INPUT_NUM, 3, log2 of element count N.
- DATAWIDTH, 32, element width.
- ADDRWIDTH, 16, word-address width of both RAM ports.
- RST_CYCLES, 4, cycles srt_rst is held high before loading (>=1).
- TIMEOUT, 4096, max cycles in WAIT with no srt_y_valid before an error is raised.
- ASCENDING, 1, expected output order; used only by the optional feature.

Ports:
- clk  in  1  clock, all logic on posedge.
- resetn  in  1  synchronous active-low reset.
- start  in  1  one-cycle pulse; ignored unless in IDLE or DONE.
- src_base  in  ADDRWIDTH  first source word address; sampled at start.
- dst_base  in  ADDRWIDTH  first destination word address; sampled at start.
- busy  out  1  high in every state except IDLE and DONE.
- done  out  1  high in DONE until the next start.
- timeout_err  out  1  set when the WAIT timeout fires; cleared by start.
- order_err  out  1  see Optional Feature.
- rd_en  out  1  source RAM read strobe.
- rd_addr  out  ADDRWIDTH  source RAM address.
- rd_data  in  DATAWIDTH  source RAM data, valid exactly 1 cycle after rd_en.
- wr_en  out  1  destination RAM write strobe.
- wr_addr  out  ADDRWIDTH  destination RAM address.
- wr_data  out  DATAWIDTH  destination RAM write data.
- srt_rst  out  1  sorter reset, active high.
- srt_din  out  DATAWIDTH  sorter input word.
- srt_now1  out  1  sorter load strobe; srt_din is accepted on each cycle it is high.
- srt_now2  out  1  sorter go strobe, one cycle.
- srt_y_valid  in  1  sorter output-valid.
- srt_dout  in  DATAWIDTH  sorter output word.

Behaviour:
- Reset (resetn low at posedge):
  - state=IDLE.
  - busy, done, timeout_err, order_err, rd_en, wr_en, srt_now1, srt_now2 = 0.
  - srt_rst=1.
  - All counters and addresses = 0.
  - Reset mid-operation aborts immediately. No further RAM writes occur.
- IDLE/DONE + start:
  - Latch src_base and dst_base; clear done, timeout_err and order_err.
  - Go to SRST.
- SRST:
  - srt_rst=1 for RST_CYCLES cycles, then srt_rst=0 and go to LOAD.
- LOAD:
  - Issue rd_en on N consecutive cycles at rd_addr = src_base + i, i = 0..N-1.
  - Each returned rd_data is driven on srt_din with srt_now1=1 in the following cycle.
  - srt_now1 is therefore high for exactly N consecutive cycles, starting 1 cycle after the first rd_en.
  - Address arithmetic wraps modulo 2**ADDRWIDTH.
- KICK:
  - Entered the cycle after the last srt_now1.
  - srt_now2=1 for one cycle, then go to WAIT with the timeout counter = 0.
- WAIT:
  - Counter increments each cycle.
  - If srt_y_valid=1: go to DRAIN and capture that word in the same cycle as output j=0.
  - If the counter reaches TIMEOUT-1 with no srt_y_valid: timeout_err=1, go to DONE with no writes.
- DRAIN:
  - Each cycle srt_y_valid=1: wr_en=1, wr_addr = dst_base + j, wr_data = srt_dout, j++. These are registered outputs, so the write appears 1 cycle after capture.
  - Cycles with srt_y_valid=0 are stalls; j holds.
  - After j reaches N, go to DONE. Any further srt_y_valid is ignored.
- DONE: done=1, busy=0.
  - start in the same cycle as DONE entry is ignored.
  - start in a later cycle restarts the sequence.
- start during busy is ignored.
- Total latency for a sorter that needs no stalls: RST_CYCLES + N + 2 + sorter latency + N + 1 cycles from start to done.

Optional Feature:
- Macro: SORT_LOADER_ORDER_CHECK_EN.
- Defined:
  - In DRAIN, each captured word is compared with the previous one, unsigned.
  - ASCENDING=1 flags cur<prev; ASCENDING=0 flags cur>prev.
  - A violation sets order_err (sticky until start).
  - Data is still written.
- Undefined: order_err is tied to 0 and no comparator is built.

Test Plan:
- N=8, src = {5,3,7,1,8,2,6,4}, model sorter returns ascending after 10 cycles:
  - dst = {1,2,3,4,5,6,7,8}.
  - srt_now1 high for exactly 8 consecutive cycles.
  - srt_now2 pulses once.
  - done=1, timeout_err=0.
- Model sorter never asserts srt_y_valid, TIMEOUT=64:
  - timeout_err=1 and done=1 exactly 64 cycles after entering WAIT.
  - wr_en never asserted.
- Sorter output with srt_y_valid low for 3 cycles between word 3 and word 4:
  - 8 writes to consecutive addresses dst_base..dst_base+7, no gaps in address, correct data.
- resetn low for 1 cycle during LOAD, then a new start:
  - Outputs return to their reset values.
  - Second run completes correctly.
  - No writes from the aborted run.
- src_base = 2**ADDRWIDTH-2:
  - Reads at FFFE, FFFF, 0000..0005 (ADDRWIDTH=16).
  - start asserted while busy has no effect.
- With SORT_LOADER_ORDER_CHECK_EN defined, model sorter emits {1,2,4,3,5,6,7,8}:
  - order_err=1 at done.
  - order_err=0 for the sorted case.

Source files
------------

// File: rtl/sort_stream_loader.sv
// Streams 2**LOG_INPUT_NUM words from a source RAM into the sort core, then writes its output to a
// destination RAM. Define SORT_LOADER_ORDER_CHECK_EN to build the output-order checker (order_err).
module sort_stream_loader #(
    parameter int LOG_INPUT_NUM = 3,
    parameter int DATAWIDTH     = 32,
    parameter int ADDRWIDTH     = 16,
    parameter int RST_CYCLES    = 4,
    parameter int TIMEOUT       = 4096,
    parameter int ASCENDING     = 1
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 start,
    input  logic [ADDRWIDTH-1:0] src_base,
    input  logic [ADDRWIDTH-1:0] dst_base,
    output logic                 busy,
    output logic                 done,
    output logic                 timeout_err,
    output logic                 order_err,
    output logic                 rd_en,
    output logic [ADDRWIDTH-1:0] rd_addr,
    input  logic [DATAWIDTH-1:0] rd_data,
    output logic                 wr_en,
    output logic [ADDRWIDTH-1:0] wr_addr,
    output logic [DATAWIDTH-1:0] wr_data,
    output logic                 srt_rst,
    output logic [DATAWIDTH-1:0] srt_din,
    output logic                 srt_now1,
    output logic                 srt_now2,
    input  logic                 srt_y_valid,
    input  logic [DATAWIDTH-1:0] srt_dout
);

    localparam int N      = 1 << LOG_INPUT_NUM;
    localparam int IDX_W  = LOG_INPUT_NUM + 1;
    localparam int RCNT_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam int TCNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [2:0] {IDLE, SRST, LOAD, KICK, WAIT, DRAIN, DONE} state_t;

    state_t               state;
    logic [ADDRWIDTH-1:0] src_q;
    logic [ADDRWIDTH-1:0] dst_q;
    logic [RCNT_W-1:0]    rcnt;
    logic [TCNT_W-1:0]    tcnt;
    logic [IDX_W-1:0]     rd_idx;
    logic [IDX_W-1:0]     wr_idx;
    logic                 capture;

    // Read data is presented to the sorter in the cycle it returns, alongside srt_now1.
    assign srt_din = rd_data;
    assign capture = ((state == WAIT) || (state == DRAIN)) && srt_y_valid;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state       <= IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            timeout_err <= 1'b0;
            rd_en       <= 1'b0;
            wr_en       <= 1'b0;
            srt_now1    <= 1'b0;
            srt_now2    <= 1'b0;
            srt_rst     <= 1'b1;
            rd_addr     <= '0;
            wr_addr     <= '0;
            src_q       <= '0;
            dst_q       <= '0;
            rcnt        <= '0;
            tcnt        <= '0;
            rd_idx      <= '0;
            wr_idx      <= '0;
        end else begin
            wr_en    <= 1'b0;
            srt_now1 <= rd_en;
            srt_now2 <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        src_q       <= src_base;
                        dst_q       <= dst_base;
                        done        <= 1'b0;
                        timeout_err <= 1'b0;
                        busy        <= 1'b1;
                        srt_rst     <= 1'b1;
                        rcnt        <= '0;
                        wr_idx      <= '0;
                        state       <= SRST;
                    end
                end
                SRST: begin
                    if (rcnt == RCNT_W'(RST_CYCLES - 1)) begin
                        srt_rst <= 1'b0;
                        rd_en   <= 1'b1;
                        rd_addr <= src_q;
                        rd_idx  <= IDX_W'(1);
                        state   <= LOAD;
                    end else begin
                        rcnt <= rcnt + 1'b1;
                    end
                end
                LOAD: begin
                    if (rd_idx != IDX_W'(N)) begin
                        rd_en   <= 1'b1;
                        rd_addr <= src_q + ADDRWIDTH'(rd_idx);
                        rd_idx  <= rd_idx + 1'b1;
                    end else begin
                        rd_en <= 1'b0;
                        // Last read already returned: this is the final srt_now1 cycle.
                        if (!rd_en) begin
                            srt_now2 <= 1'b1;
                            state    <= KICK;
                        end
                    end
                end
                KICK: begin
                    tcnt  <= '0;
                    state <= WAIT;
                end
                WAIT, DRAIN: begin
                    tcnt <= tcnt + 1'b1;
                    if (srt_y_valid) begin
                        wr_en   <= 1'b1;
                        wr_addr <= dst_q + ADDRWIDTH'(wr_idx);
                        wr_idx  <= wr_idx + 1'b1;
                        if (wr_idx == IDX_W'(N - 1)) begin
                            done  <= 1'b1;
                            busy  <= 1'b0;
                            state <= DONE;
                        end else begin
                            state <= DRAIN;
                        end
                    end else if ((state == WAIT) && (tcnt == TCNT_W'(TIMEOUT - 1))) begin
                        timeout_err <= 1'b1;
                        done        <= 1'b1;
                        busy        <= 1'b0;
                        state       <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Write data path: capture stage, no reset
    always_ff @(posedge clk) begin
        if (capture) wr_data <= srt_dout;
    end

`ifdef SORT_LOADER_ORDER_CHECK_EN
    logic [DATAWIDTH-1:0] prev_p0;
    logic                 order_err_q;

    function automatic logic out_of_order(input logic [DATAWIDTH-1:0] prev,
                                          input logic [DATAWIDTH-1:0] cur);
        return (ASCENDING != 0) ? (cur < prev) : (cur > prev);
    endfunction

    always_ff @(posedge clk) begin
        if (capture) prev_p0 <= srt_dout;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            order_err_q <= 1'b0;
        end else if (((state == IDLE) || (state == DONE)) && start) begin
            order_err_q <= 1'b0;
        end else if ((state == DRAIN) && srt_y_valid && out_of_order(prev_p0, srt_dout)) begin
            order_err_q <= 1'b1;
        end
    end

    assign order_err = order_err_q;
`else
    assign order_err = 1'b0;
`endif

endmodule
